// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use stalls, branch flushes, memory waits
// with timeout halt. Optional statistics counters are built when PIPELINE_CTRL_STATS_EN is defined.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
    logic            freeze;
    logic            load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pend_d      = pend_q;
        err_d       = err_q;
        freeze      = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        unique case (state_q)
            StRun: begin
                if (dmem_req && !dmem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = CntW'(1);
                    if (CntW'(1) >= TimeoutVal) begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StMemWait;
                    end
                end
            end
            StMemWait: begin
                if (!dmem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                    if (wait_cnt_d == TimeoutVal) begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            end
            StHalt: freeze = 1'b1;
            default: state_d = StRun;
        endcase

        // A branch seen while frozen is remembered and flushed on the first advancing cycle.
        if (freeze) begin
            pend_d = pend_q | branch_taken;
        end else if (branch_taken || pend_q) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pend_d      = 1'b0;
        end else if (load_use) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
        end

        if (!rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    assign mem_err = err_q;
    assign state   = state_q;

`ifdef PIPELINE_CTRL_STATS_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (if_id_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, which is the maximum number of consecutive data-memory wait cycles before the block halts.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port id_rs1 / id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-006 SHALL have port ex_mem_read, input, 1 bit: the EX instruction is a load.
REQ-007 SHALL have port branch_taken, input, 1 bit: branch/jump resolved taken (PCSrcD); redirects fetch.
REQ-008 SHALL have port dmem_req / dmem_ready, input, 1 bit each: MEM-stage access pending / access completes this cycle.
REQ-009 SHALL have port pc_en, if_id_en, id_ex_en, ex_mem_en, output, 1 bit each: stage-register load enables.
REQ-010 SHALL have port if_id_flush / id_ex_flush, output, 1 bit each: load a bubble (instruction 0) into that register.
REQ-011 SHALL have port mem_err, output, 1 bit: sticky timeout error.
REQ-012 SHALL have port state, output, 2 bits: RUN=0, MEM_WAIT=1, HALT=2.
REQ-013 SHALL have port stall_cycles / flush_count, output, 32 bits each: statistics counters (see Configuration).

Function
REQ-014 SHALL decode all enable and flush outputs combinationally from state, the pending-flush flag and the inputs.
REQ-015 SHALL define a load-use hazard as ex_mem_read=1, ex_rd≠0 and (ex_rd==id_rs1 or ex_rd==id_rs2).
REQ-016 SHALL, in RUN with dmem_req=0 or dmem_ready=1, set all enables to 1 and both flushes to 0 when there is no hazard and no branch.
REQ-017 SHALL, in RUN on a load-use hazard with branch_taken=0, drive pc_en=0, if_id_en=0, id_ex_flush=1 and ex_mem_en=1, giving exactly one bubble per hazard cycle.
REQ-018 SHALL, in RUN on branch_taken=1, drive if_id_flush=1 and id_ex_flush=1 with all enables 1; branch_taken overrides the load-use stall.
REQ-019 SHALL, in RUN with dmem_req=1 and dmem_ready=0, drive all four enables to 0 and both flushes to 0, transition to MEM_WAIT, and load wait_cnt with 1.
REQ-020 SHALL, in MEM_WAIT, hold all enables 0 and both flushes 0, and increment wait_cnt each cycle dmem_ready=0.
REQ-021 SHALL leave MEM_WAIT for RUN when dmem_ready=1; that cycle SHALL behave as RUN (REQ-016..018 apply).
REQ-022 SHALL set the pending flag when branch_taken=1 in any cycle in which the enables are forced 0.
REQ-023 SHALL, with the pending flag set, apply the branch flush on the first cycle the pipeline advances (once only), then clear the flag.
REQ-024 SHALL, when wait_cnt reaches MEM_TIMEOUT with dmem_ready still 0, transition to HALT and set mem_err=1.
REQ-025 SHALL, in HALT, hold all enables 0 and both flushes 0; HALT SHALL be exited only by reset.
REQ-026 SHALL size wait_cnt at $clog2(MEM_TIMEOUT+1) bits so that it never wraps.

Reset
REQ-027 SHALL, on a rising edge of clk with rst=0, set state to RUN and clear wait_cnt, the pending flag, mem_err and both counters.
REQ-028 SHALL, while rst=0, force all enables to 0 and both flushes to 1.
REQ-029 SHALL honour a reset asserted in MEM_WAIT or HALT, which aborts the wait with no pending flush retained.

Configuration
REQ-030 SHALL, when macro PIPELINE_CTRL_STATS_EN is defined, increment stall_cycles on each cycle with pc_en=0 and rst=1, and increment flush_count on each cycle with if_id_flush=1 and rst=1; both counters SHALL saturate at 32'hFFFFFFFF.
REQ-031 SHALL, when PIPELINE_CTRL_STATS_EN is undefined, keep the stall_cycles and flush_count ports present, tie both to 0, and synthesize no counter logic.

Verification
REQ-032 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 in that cycle only.
REQ-033 SHALL cover x0 exemption: ex_mem_read=1, ex_rd=0, id_rs1=0 -> no stall.
REQ-034 SHALL cover branch during wait: dmem_req=1, dmem_ready=0 for 3 cycles with branch_taken=1 in the 2nd -> state=1, enables 0 for 3 cycles, then if_id_flush=1 exactly once on release.
REQ-035 SHALL cover timeout: MEM_TIMEOUT=4 and dmem_ready held 0 -> state=2 and mem_err=1 after 4 wait cycles; both remain set until rst=0, then state=0 and mem_err=0.
REQ-036 SHALL cover simultaneous events: branch_taken=1 together with a load-use hazard -> both flushes 1, pc_en=1.
REQ-037 SHALL cover statistics with PIPELINE_CTRL_STATS_EN defined: 2 load-use stalls plus a 3-cycle wait -> stall_cycles=5; with the macro undefined -> stall_cycles=0.
